run_sequencer: RTL and testbench

Test-harness controller sitting directly upstream and downstream of the x9 CPU core. It streams an initial image into `data_mem`, pulses the core's `start`, and counts cycles until `halt`. It then streams a window of `data_mem` back out for checking. It owns the `data_mem` port only while loading and dumping; the integrator muxes `data_mem` between core and sequencer on `mem_own`.

---
 rtl/run_sequencer.sv | 145 ++++++++++++++
 tb/tb_run_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// run_sequencer: loads an image into data_mem, starts the core, times the run
// until halt or timeout, then streams a window of data_mem back out.
module run_sequencer #(
  parameter int unsigned    A            = 8,
  parameter int unsigned    START_CYCLES = 2,
  parameter logic [A-1:0]   DUMP_BASE    = '0,
  parameter logic [A:0]     DUMP_LEN     = {1'b1, {A{1'b0}}},
  parameter logic [31:0]    MAX_CYCLES   = 32'd1_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         go,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [7:0]   load_data,
  input  logic         load_last,
  output logic         mem_own,
  output logic [A-1:0] mem_addr,
  output logic         mem_wr_en,
  output logic         mem_rd_en,
  output logic [7:0]   mem_wdata,
  input  logic [7:0]   mem_rdata,
  output logic         cpu_start,
  input  logic         cpu_halt,
  output logic         dump_valid,
  input  logic         dump_ready,
  output logic [7:0]   dump_data,
  output logic         dump_last,
  output logic [31:0]  cycle_count,
  output logic         timeout,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_RUN, S_DUMP, S_DONE
  } state_e;

  localparam logic [A-1:0] PTR_MAX    = '1;
  localparam logic [A:0]   REM_ONE    = {{A{1'b0}}, 1'b1};
  localparam logic [31:0]  START_LAST = 32'(START_CYCLES) - 32'd1;

  state_e       state_q, state_d;
  logic [A-1:0] ptr_q, ptr_d;
  logic [A:0]   rem_q, rem_d;
  logic [31:0]  scnt_q, scnt_d;
  logic [31:0]  cc_q, cc_d;
  logic         to_q, to_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      scnt_q  <= '0;
      cc_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      scnt_q  <= scnt_d;
      cc_q    <= cc_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    scnt_d     = scnt_q;
    cc_d       = cc_q;
    to_d       = to_q;
    load_ready = 1'b0;
    mem_own    = 1'b0;
    mem_addr   = '0;
    mem_wr_en  = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wdata  = '0;
    cpu_start  = 1'b0;
    dump_valid = 1'b0;
    dump_data  = '0;
    dump_last  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          to_d    = 1'b0;
        end
      end
      S_LOAD: begin
        mem_own    = 1'b1;
        load_ready = 1'b1;
        mem_addr   = ptr_q;
        if (load_valid) begin
          mem_wr_en = 1'b1;
          mem_wdata = load_data;
          ptr_d     = ptr_q + 1'b1;
          if (load_last || ptr_q == PTR_MAX) begin
            state_d = S_START;
            scnt_d  = '0;
            cc_d    = '0;
          end
        end
      end
      S_START: begin
        cpu_start = 1'b1;
        scnt_d    = scnt_q + 32'd1;
        if (scnt_q == START_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        // Halt cycle is not counted; the timeout cycle is.
        if (!cpu_halt) cc_d = cc_q + 32'd1;
        if (cpu_halt || cc_d == MAX_CYCLES) begin
          to_d    = !cpu_halt;
          ptr_d   = DUMP_BASE;
          rem_d   = DUMP_LEN;
          state_d = (DUMP_LEN == '0) ? S_DONE : S_DUMP;
        end
      end
      S_DUMP: begin
        mem_own    = 1'b1;
        mem_rd_en  = 1'b1;
        mem_addr   = ptr_q;
        dump_valid = 1'b1;
        dump_data  = mem_rdata;
        dump_last  = (rem_q == REM_ONE);
        if (dump_ready) begin
          ptr_d = ptr_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == REM_ONE) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cycle_count = cc_q;
  assign timeout     = to_q;
  assign done        = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: table-driven and randomized runs of run_sequencer against
// a byte-image model of data_mem and a min(halt, limit) model of the run timer.
module tb_run_sequencer;

  localparam int          START_N = 3;
  localparam int          MAXC    = 100;
  localparam logic [7:0]  DBASE   = 8'hFE;
  localparam int          DLEN    = 4;

  logic        clk = 1'b0;
  logic        reset, go, load_valid, load_ready, load_last;
  logic [7:0]  load_data, mem_wdata, mem_rdata, dump_data;
  logic        mem_own, mem_wr_en, mem_rd_en, cpu_start, cpu_halt;
  logic [7:0]  mem_addr;
  logic        dump_valid, dump_ready, dump_last, timeout, busy, done;
  logic [31:0] cycle_count;

  logic [7:0]  ram [256];
  logic [7:0]  ref_mem [256];
  logic        ram_clr;

  int checks = 0;
  int errors = 0;
  int last_cc = 0;

  typedef struct {
    int nbytes;
    bit use_last;
    bit pat;
    int halt_after;
    bit halt_in_start;
    int rdy_mode;
    int exp_cc;
    bit exp_to;
  } vec_t;

  vec_t vecs[11];

  run_sequencer #(
    .A(8), .START_CYCLES(START_N), .DUMP_BASE(DBASE),
    .DUMP_LEN(9'(DLEN)), .MAX_CYCLES(32'(MAXC))
  ) dut (
    .clk(clk), .reset(reset), .go(go),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last),
    .mem_own(mem_own), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_rd_en(mem_rd_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_start(cpu_start), .cpu_halt(cpu_halt),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_last(dump_last),
    .cycle_count(cycle_count), .timeout(timeout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int k = 0; k < 256; k++) ram[k] <= 8'h00;
    end else if (mem_wr_en) begin
      ram[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = ram[mem_addr];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int model_cc(input int h);
    return (h >= MAXC) ? MAXC : h;
  endfunction

  task automatic chk_idle(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_to"}, timeout, 0);
    chk({nm, "_cc"}, cycle_count, 0);
    chk({nm, "_start"}, cpu_start, 0);
    chk({nm, "_own"}, mem_own, 0);
    chk({nm, "_lrdy"}, load_ready, 0);
    chk({nm, "_dv"}, dump_valid, 0);
    chk({nm, "_wr"}, mem_wr_en, 0);
    chk({nm, "_rd"}, mem_rd_en, 0);
  endtask

  task automatic load_image(input int n, input bit use_last, input bit pat);
    logic [7:0] d;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    chk("go_lrdy", load_ready, 1);
    chk("go_busy", busy, 1);
    chk("go_done_clr", done, 0);
    chk("go_to_clr", timeout, 0);
    chk("go_cc_keep", cycle_count, 32'(last_cc));
    for (int b = 0; b < n; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        load_valid = 1'b0;
        go = 1'($urandom);
        @(negedge clk);
      end
      chk("load_rdy", load_ready, 1);
      d = pat ? 8'(8'h11 * (b + 1)) : 8'($urandom);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = use_last && (b == n - 1);
      go = 1'($urandom);
      ref_mem[b] = d;
      @(negedge clk);
    end
    go = 1'b0;
    load_data = 8'hA5;
    load_last = 1'b0;
    chk("held_off", load_ready, 0);
    chk("no_extra_wr", mem_wr_en, 0);
    chk("start_hi", cpu_start, 1);
    chk("cc_clr", cycle_count, 0);
    load_valid = 1'b0;
  endtask

  task automatic do_run(input vec_t v);
    int cnt, i, guard, stop;
    bit rdy;
    logic [7:0] ea;
    load_image(v.nbytes, v.use_last, v.pat);
    cnt = 0;
    while (cpu_start === 1'b1 && cnt < 20) begin
      cnt++;
      cpu_halt = v.halt_in_start;
      @(negedge clk);
    end
    chk("start_len", cnt, START_N);
    cpu_halt = 1'b0;
    stop = (v.halt_after < MAXC) ? v.halt_after : MAXC;
    repeat (stop) @(negedge clk);
    if (v.halt_after < MAXC) begin
      chk("cc_prehalt", cycle_count, 32'(v.halt_after));
      cpu_halt = 1'b1;
      @(negedge clk);
      cpu_halt = 1'b0;
    end
    chk("dump_lat", dump_valid, 1);
    i = 0;
    guard = 0;
    while (i < DLEN && guard < 100) begin
      ea = DBASE + 8'(i);
      chk("dump_v", dump_valid, 1);
      chk("dump_own", mem_own, 1);
      chk("dump_a", mem_addr, ea);
      chk("dump_d", dump_data, ref_mem[ea]);
      chk("dump_l", dump_last, (i == DLEN - 1));
      case (v.rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (guard % 3) == 0;
        default: rdy = 1'($urandom);
      endcase
      dump_ready = rdy;
      @(negedge clk);
      if (rdy) i++;
      guard++;
    end
    chk("dump_beats", i, DLEN);
    dump_ready = 1'b0;
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_dv", dump_valid, 0);
    chk("end_own", mem_own, 0);
    chk("end_cc", cycle_count, 32'(v.exp_cc));
    chk("end_to", timeout, v.exp_to);
    @(negedge clk);
    chk("done_stable_cc", cycle_count, 32'(v.exp_cc));
    chk("done_stable_to", timeout, v.exp_to);
    last_cc = v.exp_cc;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int h;
    reset = 1'b1; ram_clr = 1'b1; go = 1'b0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    cpu_halt = 1'b0; dump_ready = 1'b0;
    for (int k = 0; k < 256; k++) ref_mem[k] = 8'h00;

    vecs[0] = '{256, 1'b0, 1'b0, 5,    1'b0, 0, 5,   1'b0};
    vecs[1] = '{4,   1'b1, 1'b1, 37,   1'b0, 0, 37,  1'b0};
    vecs[2] = '{8,   1'b1, 1'b0, 12,   1'b0, 1, 12,  1'b0};
    vecs[3] = '{3,   1'b1, 1'b0, 1000, 1'b0, 0, 100, 1'b1};
    vecs[4] = '{5,   1'b1, 1'b0, 10,   1'b1, 0, 10,  1'b0};
    for (int r = 5; r < 11; r++) begin
      h = $urandom_range(0, 130);
      vecs[r] = '{$urandom_range(1, 40), 1'b1, 1'b0, h,
                  1'($urandom), 2, model_cc(h), (h >= MAXC)};
    end

    repeat (3) @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;
    ram_clr = 1'b0;

    for (int r = 0; r < 11; r++) do_run(vecs[r]);

    load_image(2, 1'b1, 1'b0);
    while (cpu_start === 1'b1) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("mid_run_cc", cycle_count, 5);
    chk("mid_run_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("mid_rst");
    reset = 1'b0;
    last_cc = 0;

    do_run(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
